// File: rtl/axi_isolate_seq_pkg.sv
// rtl/axi_isolate_seq_pkg.sv - shared types and width helpers for the AXI isolation sequencer
package axi_isolate_seq_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } state_e;

  // Bits needed to hold 0..n inclusive; never less than one bit so a disabled
  // watchdog (n = 0) still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_isolate_seq_if.sv
// rtl/axi_isolate_seq_if.sv - per-port handshake events in, gating and status out
interface axi_isolate_seq_if #(
  parameter int unsigned NumPorts = 4
);

  logic [NumPorts-1:0] isolate_i;
  logic [NumPorts-1:0] aw_hs_i;
  logic [NumPorts-1:0] ar_hs_i;
  logic [NumPorts-1:0] b_hs_i;
  logic [NumPorts-1:0] r_last_hs_i;
  logic [NumPorts-1:0] gate_o;
  logic [NumPorts-1:0] isolated_o;
  logic [NumPorts-1:0] timeout_o;
  logic [NumPorts-1:0] proto_err_o;

  modport master (
    output isolate_i, aw_hs_i, ar_hs_i, b_hs_i, r_last_hs_i,
    input  gate_o, isolated_o, timeout_o, proto_err_o
  );

  modport slave (
    input  isolate_i, aw_hs_i, ar_hs_i, b_hs_i, r_last_hs_i,
    output gate_o, isolated_o, timeout_o, proto_err_o
  );

endinterface

// File: rtl/axi_isolate_seq_port.sv
// rtl/axi_isolate_seq_port.sv - one port: burst counters, drain FSM, watchdog and sticky error
module axi_isolate_seq_port
  import axi_isolate_seq_pkg::*;
#(
  parameter int unsigned MaxPending    = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter bit          ResetIsolated = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic isolate_i,
  input  logic aw_hs_i,
  input  logic ar_hs_i,
  input  logic b_hs_i,
  input  logic r_last_hs_i,
  output logic gate_o,
  output logic isolated_o,
  output logic timeout_o,
  output logic proto_err_o
);

  localparam int unsigned CntWidth = cnt_width(MaxPending);
  localparam int unsigned TmrWidth = cnt_width(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxPending);
  localparam logic [TmrWidth-1:0] TmrLast =
    (TimeoutCycles == 0) ? '0 : TmrWidth'(TimeoutCycles - 1);
  localparam state_e ResetState = ResetIsolated ? ISOLATED : RUN;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic [TmrWidth-1:0] timer_q, timer_d;
  logic                timeout_d;
  logic                proto_err_d;
  logic                drained;
  logic                gate_d;

  // Saturating up/down counter; simultaneous inc and dec cancel out.
  function automatic logic [CntWidth-1:0] cnt_next(
    input logic [CntWidth-1:0] cnt,
    input logic                inc,
    input logic                dec
  );
    logic [CntWidth-1:0] nxt;
    nxt = cnt;
    if (inc && !dec && (cnt != CntMax)) begin
      nxt = cnt + CntWidth'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      nxt = cnt - CntWidth'(1);
    end
    return nxt;
  endfunction

  always_comb begin
    wr_cnt_d    = cnt_next(wr_cnt_q, aw_hs_i, b_hs_i);
    rd_cnt_d    = cnt_next(rd_cnt_q, ar_hs_i, r_last_hs_i);
    proto_err_d = proto_err_o
                | (b_hs_i && (wr_cnt_q == '0))
                | (r_last_hs_i && (rd_cnt_q == '0));
    drained     = (wr_cnt_d == '0) && (rd_cnt_d == '0);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = timeout_o;
    unique case (state_q)
      RUN: begin
        if (isolate_i) begin
          state_d = DRAIN;
          timer_d = '0;
        end
      end
      DRAIN: begin
        if (!isolate_i) begin
          state_d = RUN;
        end else if (drained) begin
          state_d = ISOLATED;
        end else if ((TimeoutCycles != 0) && (timer_q == TmrLast)) begin
          state_d   = ISOLATED;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TmrWidth'(1);
        end
      end
      ISOLATED: begin
        if (!isolate_i) begin
          state_d   = RUN;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = ISOLATED;
      end
    endcase
  end

  // Gate looks at next-cycle values so a handshake landing on the same edge
  // as the isolate request or the last free slot is already covered.
  assign gate_d = (state_d != RUN) || (wr_cnt_d == CntMax) || (rd_cnt_d == CntMax);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ResetState;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      timer_q     <= '0;
      gate_o      <= ResetIsolated;
      isolated_o  <= ResetIsolated;
      timeout_o   <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      timer_q     <= timer_d;
      gate_o      <= gate_d;
      isolated_o  <= (state_d == ISOLATED);
      timeout_o   <= timeout_d;
      proto_err_o <= proto_err_d;
    end
  end

endmodule

// File: rtl/axi_isolate_seq.sv
// rtl/axi_isolate_seq.sv - NumPorts independent isolation sequencers sharing one island clock
module axi_isolate_seq
  import axi_isolate_seq_pkg::*;
#(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned MaxPending    = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter bit          ResetIsolated = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  axi_isolate_seq_if.slave  bus
);

  logic [NumPorts-1:0] gate;
  logic [NumPorts-1:0] isolated;
  logic [NumPorts-1:0] timeout;
  logic [NumPorts-1:0] proto_err;

  for (genvar g = 0; g < NumPorts; g++) begin : g_port
    axi_isolate_seq_port #(
      .MaxPending    (MaxPending),
      .TimeoutCycles (TimeoutCycles),
      .ResetIsolated (ResetIsolated)
    ) u_port (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .isolate_i   (bus.isolate_i[g]),
      .aw_hs_i     (bus.aw_hs_i[g]),
      .ar_hs_i     (bus.ar_hs_i[g]),
      .b_hs_i      (bus.b_hs_i[g]),
      .r_last_hs_i (bus.r_last_hs_i[g]),
      .gate_o      (gate[g]),
      .isolated_o  (isolated[g]),
      .timeout_o   (timeout[g]),
      .proto_err_o (proto_err[g])
    );
  end

  assign bus.gate_o      = gate;
  assign bus.isolated_o  = isolated;
  assign bus.timeout_o   = timeout;
  assign bus.proto_err_o = proto_err;

endmodule

// File: tb/tb_axi_isolate_seq.sv
// tb/tb_axi_isolate_seq.sv - scoreboard bench for axi_isolate_seq
module tb_axi_isolate_seq;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  axi_isolate_seq_if #(.NumPorts(NP)) bus ();

  axi_isolate_seq #(
    .NumPorts      (NP),
    .MaxPending    (8),
    .TimeoutCycles (16),
    .ResetIsolated (1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // exp bits: {gate, isolated, timeout, proto_err}; port -1 checks every port.
  typedef struct {
    int         cyc;
    int         port;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] obs(input int p);
    return {bus.gate_o[p], bus.isolated_o[p], bus.timeout_o[p], bus.proto_err_o[p]};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [4*NP-1:0] act_all;
    logic [4*NP-1:0] exp_all;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s expectation for cycle %0d reached at cycle %0d", e.name, e.cyc, cyc);
      end else if (e.port < 0) begin
        for (int p = 0; p < NP; p++) begin
          act_all[4*p +: 4] = obs(p);
          exp_all[4*p +: 4] = e.exp;
        end
        if (act_all !== exp_all) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b", e.name, cyc, act_all, exp_all);
        end
      end else if (obs(e.port) !== e.exp) begin
        errors++;
        $display("FAIL %s port %0d cyc %0d got %b want %b (gate,iso,tmo,err)",
                 e.name, e.port, cyc, obs(e.port), e.exp);
      end
    end
  end

  task automatic step(input int port, input logic [3:0] exp, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.aw_hs_i     = '0;
    bus.ar_hs_i     = '0;
    bus.b_hs_i      = '0;
    bus.r_last_hs_i = '0;
  endtask

  initial begin
    rst_ni          = 1'b0;
    bus.isolate_i   = '1;
    bus.aw_hs_i     = '0;
    bus.ar_hs_i     = '0;
    bus.b_hs_i      = '0;
    bus.r_last_hs_i = '0;

    step(-1, 4'b1100, "reset");
    step(-1, 4'b1100, "reset_hold");
    rst_ni = 1'b1;
    step(-1, 4'b1100, "iso_after_reset");
    bus.isolate_i = '0;
    step(-1, 4'b0000, "run_after_release");

    // Port 0: write counting, then read throttle at MaxPending.
    for (int k = 0; k < 3; k++) begin bus.aw_hs_i[0] = 1'b1; step(0, 4'b0000, "p0_aw"); end
    for (int k = 0; k < 3; k++) begin bus.b_hs_i[0] = 1'b1; step(0, 4'b0000, "p0_b"); end
    for (int k = 1; k <= 8; k++) begin
      bus.ar_hs_i[0] = 1'b1;
      step(0, (k == 8) ? 4'b1000 : 4'b0000, "p0_rd_fill");
    end
    step(0, 4'b1000, "p0_rd_full_hold");
    bus.r_last_hs_i[0] = 1'b1; step(0, 4'b0000, "p0_first_r");
    for (int k = 0; k < 7; k++) begin bus.r_last_hs_i[0] = 1'b1; step(0, 4'b0000, "p0_r_drain"); end
    bus.isolate_i[0] = 1'b1;
    step(0, 4'b1000, "p0_drain");
    step(0, 4'b1100, "p0_iso_two_cycles");
    bus.isolate_i[0] = 1'b0;
    step(0, 4'b0000, "p0_run");

    // Port 1: drain two outstanding writes.
    for (int k = 0; k < 2; k++) begin bus.aw_hs_i[1] = 1'b1; step(1, 4'b0000, "p1_aw"); end
    bus.isolate_i[1] = 1'b1;
    step(1, 4'b1000, "p1_drain");
    bus.b_hs_i[1] = 1'b1; step(1, 4'b1000, "p1_first_b");
    bus.b_hs_i[1] = 1'b1; step(1, 4'b1100, "p1_isolated");
    bus.isolate_i[1] = 1'b0;
    step(1, 4'b0000, "p1_run");

    // Port 2: watchdog expiry with a read that never returns.
    bus.ar_hs_i[2] = 1'b1; step(2, 4'b0000, "p2_ar");
    bus.isolate_i[2] = 1'b1;
    step(2, 4'b1000, "p2_drain_enter");
    for (int k = 0; k < 15; k++) step(2, 4'b1000, "p2_drain_wait");
    step(2, 4'b1110, "p2_timeout");
    bus.r_last_hs_i[2] = 1'b1; step(2, 4'b1110, "p2_late_r");
    bus.isolate_i[2] = 1'b0;
    step(2, 4'b0000, "p2_run_tmo_clr");
    bus.isolate_i[2] = 1'b1;
    step(2, 4'b1000, "p2_redrain");
    step(2, 4'b1100, "p2_rd_cnt_zero");
    bus.isolate_i[2] = 1'b0;
    step(2, 4'b0000, "p2_run_again");

    // Port 3: same-cycle inc/dec, refill to the limit, then underflow.
    for (int k = 0; k < 2; k++) begin bus.aw_hs_i[3] = 1'b1; step(3, 4'b0000, "p3_aw"); end
    bus.aw_hs_i[3] = 1'b1; bus.b_hs_i[3] = 1'b1; step(3, 4'b0000, "p3_same_cycle");
    for (int k = 1; k <= 6; k++) begin
      bus.aw_hs_i[3] = 1'b1;
      step(3, (k == 6) ? 4'b1000 : 4'b0000, "p3_fill_from_two");
    end
    for (int k = 0; k < 8; k++) begin bus.b_hs_i[3] = 1'b1; step(3, 4'b0000, "p3_b_empty"); end
    bus.b_hs_i[3] = 1'b1; step(3, 4'b0001, "p3_proto_err");
    step(3, 4'b0001, "p3_err_sticky");
    bus.isolate_i[3] = 1'b1;
    step(3, 4'b1001, "p3_drain");
    step(3, 4'b1101, "p3_wr_cnt_zero");

    // Port 0: abort mid-drain, then reset mid-drain.
    bus.aw_hs_i[0] = 1'b1; step(0, 4'b0000, "p0_aw_pending");
    bus.isolate_i[0] = 1'b1;
    step(0, 4'b1000, "p0_drain_pending");
    step(0, 4'b1000, "p0_drain_wait");
    bus.isolate_i[0] = 1'b0;
    step(0, 4'b0000, "p0_abort");
    bus.isolate_i[0] = 1'b1;
    step(0, 4'b1000, "p0_drain_again");
    rst_ni = 1'b0;
    step(-1, 4'b1100, "reset_mid_drain");
    rst_ni = 1'b1;
    bus.isolate_i = '1;
    step(-1, 4'b1100, "iso_after_reset2");
    bus.isolate_i[0] = 1'b0;
    step(0, 4'b0000, "p0_run_after_reset");
    bus.isolate_i[0] = 1'b1;
    step(0, 4'b1000, "p0_drain_after_reset");
    step(0, 4'b1100, "p0_cnt_zero_after_reset");

    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain %0d expectations left, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
